symbol_mapper: RTL and testbench

Transmit-side constellation mapper. It accepts bytes over a valid/ready handshake and serialises each byte MSB-first into QPSK or 16QAM I/Q symbols. Its output is an exact inverse of the receive-chain demapper: same bit-to-point assignment and same ±10000/±30000 amplitude grid, so a loopback reproduces the original bits. It sits between the framing/scrambler stage and the TX pulse-shaping filter.

---
 rtl/symbol_mapper.sv | 116 +++++++++++
 tb/tb_symbol_mapper.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_mapper.sv
// rtl/symbol_mapper.sv - byte-to-QPSK/16QAM symbol mapper with valid/ready handshake on both sides
module symbol_mapper #(
    parameter int AMP1 = 10000,
    parameter int AMP3 = 30000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         mod_type,
    input  logic [7:0]         in_byte,
    input  logic               in_last,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [15:0] sym_re,
    output logic signed [15:0] sym_im,
    output logic               sym_last,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               err_mod
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic signed [15:0] POS1 = 16'(AMP1);
    localparam logic signed [15:0] NEG1 = 16'(-AMP1);
    localparam logic signed [15:0] POS3 = 16'(AMP3);
    localparam logic signed [15:0] NEG3 = 16'(-AMP3);

    state_t     state, state_nx;
    logic [7:0] shreg, shreg_nx;
    logic       mode_q, mode_nx;
    logic       last_q, last_nx;
    logic [2:0] cnt, cnt_nx;
    logic       err_q, err_nx;

    logic       accept;
    logic       xfer;
    logic       supported;

    function automatic logic signed [15:0] qam_level(input logic [1:0] b);
        case (b)
            2'b00:   return NEG3;
            2'b01:   return NEG1;
            2'b10:   return POS1;
            default: return POS3;
        endcase
    endfunction

    assign sym_valid = (state == SEND);
    assign xfer      = sym_valid && sym_ready;
    assign in_ready  = (state == IDLE) || (xfer && cnt == 3'd1);
    assign accept    = in_valid && in_ready;
    assign supported = (mod_type == 4'd0) || (mod_type == 4'd1);
    assign sym_last  = sym_valid && last_q && (cnt == 3'd1);
    assign err_mod   = err_q;

    // Symbol is decoded straight from the top of the shift register, so it holds under backpressure.
    always_comb begin
        sym_re = '0;
        sym_im = '0;
        if (state == SEND) begin
            if (mode_q) begin
                sym_re = qam_level(shreg[7:6]);
                sym_im = qam_level(shreg[5:4]);
            end else begin
                sym_re = shreg[7] ? NEG1 : POS1;
                sym_im = shreg[6] ? NEG1 : POS1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        mode_nx  = mode_q;
        last_nx  = last_q;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        if (xfer) begin
            shreg_nx = mode_q ? (shreg << 4) : (shreg << 2);
            cnt_nx   = cnt - 3'd1;
            if (cnt == 3'd1)
                state_nx = IDLE;
        end
        // A new byte taken alongside the final symbol overrides the drain so there is no bubble.
        if (accept) begin
            if (supported) begin
                state_nx = SEND;
                shreg_nx = in_byte;
                mode_nx  = mod_type[0];
                last_nx  = in_last;
                cnt_nx   = mod_type[0] ? 3'd2 : 3'd4;
            end else begin
                err_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            mode_q <= 1'b0;
            last_q <= 1'b0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            mode_q <= mode_nx;
            last_q <= last_nx;
            cnt    <= cnt_nx;
            err_q  <= err_nx;
        end
    end

endmodule

// File: tb/tb_symbol_mapper.sv
// tb/tb_symbol_mapper.sv - randomized self-checking bench for symbol_mapper
module tb_symbol_mapper;

    localparam int A1 = 10000;
    localparam int A3 = 30000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         mod_type;
    logic [7:0]         in_byte;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] sym_re;
    logic signed [15:0] sym_im;
    logic               sym_last;
    logic               sym_valid;
    logic               sym_ready;
    logic               err_mod;

    int tests = 0;
    int fails = 0;

    logic [7:0] q_byte[$];
    logic [3:0] q_mod[$];
    logic       q_last[$];

    symbol_mapper #(.AMP1(A1), .AMP3(A3)) dut (
        .clk(clk), .rst_n(rst_n), .mod_type(mod_type), .in_byte(in_byte),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .sym_re(sym_re), .sym_im(sym_im), .sym_last(sym_last),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .err_mod(err_mod)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sym(input string name, input logic v, input int re, input int im);
        tests++;
        if (sym_valid !== v || (v && (sym_re !== 16'(re) || sym_im !== 16'(im)))) begin
            fails++;
            $display("FAIL %s: got valid=%0b (%0d,%0d) want valid=%0b (%0d,%0d)",
                     name, sym_valid, sym_re, sym_im, v, re, im);
        end
    endtask

    // Feeds q_* through the DUT with random ready/valid gaps and checks every symbol against a model queue.
    task automatic run_stream(input string name, input int ready_pct, input bit cont_valid,
                              input bit gapless);
        logic signed [15:0] e_re[$];
        logic signed [15:0] e_im[$];
        logic               e_last[$];
        int lv[4];
        int n, idx, cyc, drain, first_v, last_x, nsym, n_err, n_err_exp, bits;
        bit hold;
        logic signed [15:0] h_re, h_im;
        logic h_last;
        lv = '{-A3, -A1, A1, A3};
        n = q_byte.size();
        idx = 0; cyc = 0; drain = 0; first_v = -1; last_x = -1; n_err = 0; n_err_exp = 0;
        hold = 0; h_re = '0; h_im = '0; h_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (q_mod[i] == 4'd0) begin
                for (int k = 0; k < 4; k++) begin
                    bits = (int'(q_byte[i]) >> (6 - 2 * k)) & 3;
                    e_re.push_back(16'((bits >= 2) ? -A1 : A1));
                    e_im.push_back(16'((bits % 2 == 1) ? -A1 : A1));
                    e_last.push_back(q_last[i] && k == 3);
                end
            end else if (q_mod[i] == 4'd1) begin
                for (int k = 0; k < 2; k++) begin
                    bits = (int'(q_byte[i]) >> (4 - 4 * k)) & 15;
                    e_re.push_back(16'(lv[bits / 4]));
                    e_im.push_back(16'(lv[bits % 4]));
                    e_last.push_back(q_last[i] && k == 1);
                end
            end else begin
                n_err_exp++;
            end
        end
        nsym = e_re.size();
        while (drain < 3 && cyc < 4000) begin
            in_valid = (idx < n) && (cont_valid || $urandom_range(0, 1) == 1);
            if (in_valid) begin
                in_byte  = q_byte[idx];
                mod_type = q_mod[idx];
                in_last  = q_last[idx];
            end else begin
                in_byte  = 8'($urandom);
                mod_type = 4'($urandom);
                in_last  = 1'($urandom);
            end
            sym_ready = ($urandom_range(0, 99) < ready_pct);
            #3;
            if (hold) begin
                tests++;
                if (!sym_valid || sym_re !== h_re || sym_im !== h_im || sym_last !== h_last) begin
                    fails++;
                    $display("FAIL %s hold: got v=%0b (%0d,%0d,%0b) want v=1 (%0d,%0d,%0b)", name,
                             sym_valid, sym_re, sym_im, sym_last, h_re, h_im, h_last);
                end
            end
            if (err_mod) n_err++;
            if (sym_valid && first_v < 0) first_v = cyc;
            if (sym_valid && sym_ready) begin
                tests++;
                last_x = cyc;
                if (e_re.size() == 0) begin
                    fails++;
                    $display("FAIL %s extra symbol: got (%0d,%0d) want none", name, sym_re, sym_im);
                end else begin
                    if (sym_re !== e_re[0] || sym_im !== e_im[0] || sym_last !== e_last[0]) begin
                        fails++;
                        $display("FAIL %s symbol %0d: got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)",
                                 name, nsym - e_re.size(), sym_re, sym_im, sym_last,
                                 e_re[0], e_im[0], e_last[0]);
                    end
                    void'(e_re.pop_front());
                    void'(e_im.pop_front());
                    void'(e_last.pop_front());
                end
            end
            hold = sym_valid && !sym_ready;
            h_re = sym_re; h_im = sym_im; h_last = sym_last;
            if (in_valid && in_ready) idx++;
            if (idx == n && e_re.size() == 0) drain++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        tests++;
        if (idx != n || e_re.size() != 0) begin
            fails++;
            $display("FAIL %s completion: got %0d/%0d bytes, %0d symbols pending want all bytes, 0 pending",
                     name, idx, n, e_re.size());
        end
        tests++;
        if (n_err != n_err_exp) begin
            fails++;
            $display("FAIL %s err_mod pulses: got %0d want %0d", name, n_err, n_err_exp);
        end
        if (gapless) begin
            tests++;
            if (last_x - first_v + 1 != nsym) begin
                fails++;
                $display("FAIL %s gapless: got span %0d want %0d", name, last_x - first_v + 1, nsym);
            end
        end
        q_byte.delete();
        q_mod.delete();
        q_last.delete();
    endtask

    task automatic test_reset();
        #2;
        check_sym("reset_async", 1'b0, 0, 0);
        tests++;
        if (sym_re !== 16'sd0 || sym_im !== 16'sd0 || sym_last !== 1'b0 || err_mod !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got re=%0d im=%0d last=%0b err=%0b want 0 0 0 0",
                     sym_re, sym_im, sym_last, err_mod);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        #3;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_qpsk_basic();
        int er[4];
        int ei[4];
        er = '{A1, A1, -A1, -A1};
        ei = '{A1, -A1, A1, -A1};
        in_valid = 1'b1; in_byte = 8'h1B; mod_type = 4'd0; in_last = 1'b0; sym_ready = 1'b1;
        #3;
        check_sym("qpsk_accept_cycle", 1'b0, 0, 0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #3;
            check_sym($sformatf("qpsk_1b_sym%0d", k), 1'b1, er[k], ei[k]);
            if (k < 3) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL qpsk_in_ready_sym%0d: got %0b want 0", k, in_ready);
                end
            end
            tick();
        end
        #3;
        check_sym("qpsk_after", 1'b0, 0, 0);
        tick();
    endtask

    task automatic test_qam_last();
        q_byte.push_back(8'h9C); q_mod.push_back(4'd1); q_last.push_back(1'b1);
        run_stream("qam_last", 100, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_byte = 8'hF0; mod_type = 4'd1; in_last = 1'b0; sym_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #3;
            check_sym($sformatf("bp_hold%0d", k), 1'b1, A3, A3);
            tick();
        end
        sym_ready = 1'b1;
        #3;
        check_sym("bp_release", 1'b1, A3, A3);
        tick();
        #3;
        check_sym("bp_second", 1'b1, -A3, -A3);
        tick();
        #3;
        check_sym("bp_done", 1'b0, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        q_byte.push_back(8'h00); q_mod.push_back(4'd0); q_last.push_back(1'b0);
        q_byte.push_back(8'hFF); q_mod.push_back(4'd0); q_last.push_back(1'b1);
        run_stream("b2b_qpsk", 100, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            q_byte.push_back(8'($urandom)); q_mod.push_back(4'(i % 2)); q_last.push_back(1'b0);
        end
        run_stream("b2b_mixed", 100, 1'b1, 1'b1);
    endtask

    task automatic test_unsupported();
        in_valid = 1'b1; in_byte = 8'hAA; mod_type = 4'd5; in_last = 1'b1; sym_ready = 1'b1;
        #3;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL unsup_accept: got in_ready=%0b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #3;
        tests++;
        if (err_mod !== 1'b1 || sym_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL unsup_pulse: got err=%0b valid=%0b ready=%0b want 1 0 1",
                     err_mod, sym_valid, in_ready);
        end
        tick();
        #3;
        tests++;
        if (err_mod !== 1'b0 || sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL unsup_after: got err=%0b valid=%0b want 0 0", err_mod, sym_valid);
        end
        tick();
    endtask

    task automatic test_mod_switch();
        in_valid = 1'b1; in_byte = 8'h1B; mod_type = 4'd0; in_last = 1'b0; sym_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        mod_type = 4'd1;
        #3;
        check_sym("modsw_sym0", 1'b1, A1, A1);
        tick();
        #3;
        check_sym("modsw_sym1", 1'b1, A1, -A1);
        tick();
        #3;
        check_sym("modsw_sym2", 1'b1, -A1, A1);
        tick();
        #3;
        check_sym("modsw_sym3", 1'b1, -A1, -A1);
        tick();
        #3;
        check_sym("modsw_done", 1'b0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid_byte();
        in_valid = 1'b1; in_byte = 8'h1B; mod_type = 4'd0; in_last = 1'b1; sym_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_sym("rst_mid", 1'b0, 0, 0);
        tests++;
        if (sym_re !== 16'sd0 || sym_im !== 16'sd0 || sym_last !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got re=%0d im=%0d last=%0b want 0 0 0",
                     sym_re, sym_im, sym_last);
        end
        tick();
        rst_n = 1'b1;
        tick();
        q_byte.push_back(8'h1B); q_mod.push_back(4'd0); q_last.push_back(1'b1);
        run_stream("rst_fresh", 100, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0] m;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) begin
                m = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
                q_byte.push_back(8'($urandom));
                q_mod.push_back(m);
                q_last.push_back(1'($urandom));
            end
            run_stream($sformatf("random%0d", r), 30 + 30 * r, r == 2, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_byte = '0; mod_type = '0; in_last = 1'b0; sym_ready = 1'b0;
        test_reset();
        test_qpsk_basic();
        test_qam_last();
        test_backpressure();
        test_back_to_back();
        test_unsupported();
        test_mod_switch();
        test_reset_mid_byte();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
